// File: rtl/wb_arbiter_pkg.sv
// Shared constants and types for the register-file write-back arbiter.
// Contents: register address width, requester count, requester index constants,
// and the register address type.
package wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REQ    = 2;

  // Requester indices into valid/grant vectors.
  localparam int REQ_EXE  = 0;  // execute unit
  localparam int REQ_LOAD = 1;  // load unit

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between the two write-back requesters and the register file write port.
// Requester side: reqN_valid/addr/data in, reqN_ready out (valid/ready handshake).
// Write side: a3/di3/we3 register file port, plus fwd_* bypass tap for decode.
interface wb_arbiter_if #(
  parameter int XLEN = 32
);
  import wb_arbiter_pkg::*;

  logic            req0_valid;
  reg_addr_t       req0_addr;
  logic [XLEN-1:0] req0_data;
  logic            req0_ready;

  logic            req1_valid;
  reg_addr_t       req1_addr;
  logic [XLEN-1:0] req1_data;
  logic            req1_ready;

  reg_addr_t       a3;
  logic [XLEN-1:0] di3;
  logic            we3;

  logic            fwd_valid;
  reg_addr_t       fwd_addr;
  logic [XLEN-1:0] fwd_data;

  // Requesters plus register file / decode observer.
  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  a3, di3, we3,
    input  fwd_valid, fwd_addr, fwd_data
  );

  // The arbiter itself.
  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output a3, di3, we3,
    output fwd_valid, fwd_addr, fwd_data
  );

endinterface

// File: rtl/wb_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: one-hot grant from a valid vector, last winner remembered.
// Latency: grant is combinational from valid/stall/reset; last_grant updates at the edge.
// Backpressure: stall or reset forces grant to zero; no grant ever without valid.
// Ports: clk, reset (sync, active-high), stall, valid[NUM_REQ], grant[NUM_REQ] (one-hot or zero).
module rr_arbiter2
  import wb_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic [NUM_REQ-1:0] valid,
  output logic [NUM_REQ-1:0] grant
);

  logic last_grant;

  always_comb begin
    grant = '0;
    // Reset gates grant so a handshake cannot complete in a reset cycle.
    if (!reset && !stall) begin
      if (valid[REQ_EXE] && valid[REQ_LOAD]) begin
        // Conflict: the requester that did not win last time goes now.
        if (last_grant == 1'(REQ_LOAD)) begin
          grant[REQ_EXE] = 1'b1;
        end else begin
          grant[REQ_LOAD] = 1'b1;
        end
      end else begin
        grant = valid;
      end
    end
  end

  // Reset to LOAD so the execute unit wins the first conflict.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'(REQ_LOAD);
    end else if (|grant) begin
      last_grant <= grant[REQ_LOAD];
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: shares the register file write port between execute and load units.
// Latency: grant in cycle N -> we3/a3/di3 (and fwd_*) valid in cycle N+1; one write per cycle.
// Backpressure: ready only to the round-robin winner; stall or reset deasserts both readys.
// Ports: clk, reset (sync, active-high), stall, bus (slave modport: requesters + write port + fwd tap).
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  wb_arbiter_if.slave  bus
);

  logic [NUM_REQ-1:0] valid;
  logic [NUM_REQ-1:0] grant;

  reg_addr_t       sel_addr;
  logic [XLEN-1:0] sel_data;

  reg_addr_t       a3_q;
  logic [XLEN-1:0] di3_q;
  logic            we3_q;

  assign valid[REQ_EXE]  = bus.req0_valid;
  assign valid[REQ_LOAD] = bus.req1_valid;

  rr_arbiter2 u_rr (
    .clk   (clk),
    .reset (reset),
    .stall (stall),
    .valid (valid),
    .grant (grant)
  );

  // Ready is just the grant: depends only on valid, stall, reset and last_grant.
  assign bus.req0_ready = grant[REQ_EXE];
  assign bus.req1_ready = grant[REQ_LOAD];

  always_comb begin
    sel_addr = bus.req0_addr;
    sel_data = bus.req0_data;
    if (grant[REQ_LOAD]) begin
      sel_addr = bus.req1_addr;
      sel_data = bus.req1_data;
    end
  end

  // Write stage. x0 writes complete the handshake but never pulse we3.
  // a3/di3 hold across idle cycles; only we3 drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      a3_q  <= '0;
      di3_q <= '0;
      we3_q <= 1'b0;
    end else if (|grant) begin
      a3_q  <= sel_addr;
      di3_q <= sel_data;
      we3_q <= (sel_addr != '0);
    end else begin
      we3_q <= 1'b0;
    end
  end

  assign bus.a3  = a3_q;
  assign bus.di3 = di3_q;
  assign bus.we3 = we3_q;

  // Bypass tap: the in-flight write, visible to decode in the same cycle it issues.
  assign bus.fwd_valid = we3_q;
  assign bus.fwd_addr  = a3_q;
  assign bus.fwd_data  = di3_q;

endmodule
